// File: rtl/strassen_pkg.sv
// Shared definitions for the Strassen 2x2 sequencer: ALU op codes,
// register-file map, micro-op layout and FSM state encoding.
package strassen_pkg;

    localparam int UOP_OP_W  = 3;
    localparam int REG_IDX_W = 5;
    localparam int PC_W      = 5;
    localparam int NUM_REGS  = 21;
    localparam int NUM_UOPS  = 25;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(NUM_UOPS - 1);

    localparam logic [UOP_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [UOP_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [UOP_OP_W-1:0] OP_MUL = 3'd2;

    localparam logic [REG_IDX_W-1:0] REG_A11 = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_A12 = 5'd1;
    localparam logic [REG_IDX_W-1:0] REG_A21 = 5'd2;
    localparam logic [REG_IDX_W-1:0] REG_A22 = 5'd3;
    localparam logic [REG_IDX_W-1:0] REG_B11 = 5'd4;
    localparam logic [REG_IDX_W-1:0] REG_B12 = 5'd5;
    localparam logic [REG_IDX_W-1:0] REG_B21 = 5'd6;
    localparam logic [REG_IDX_W-1:0] REG_B22 = 5'd7;
    localparam logic [REG_IDX_W-1:0] REG_M1  = 5'd8;
    localparam logic [REG_IDX_W-1:0] REG_M2  = 5'd9;
    localparam logic [REG_IDX_W-1:0] REG_M3  = 5'd10;
    localparam logic [REG_IDX_W-1:0] REG_M4  = 5'd11;
    localparam logic [REG_IDX_W-1:0] REG_M5  = 5'd12;
    localparam logic [REG_IDX_W-1:0] REG_M6  = 5'd13;
    localparam logic [REG_IDX_W-1:0] REG_M7  = 5'd14;
    localparam logic [REG_IDX_W-1:0] REG_T0  = 5'd15;
    localparam logic [REG_IDX_W-1:0] REG_T1  = 5'd16;
    localparam logic [REG_IDX_W-1:0] REG_C11 = 5'd17;
    localparam logic [REG_IDX_W-1:0] REG_C12 = 5'd18;
    localparam logic [REG_IDX_W-1:0] REG_C21 = 5'd19;
    localparam logic [REG_IDX_W-1:0] REG_C22 = 5'd20;

    typedef struct packed {
        logic [UOP_OP_W-1:0]  op;
        logic [REG_IDX_W-1:0] srcA;
        logic [REG_IDX_W-1:0] srcB;
        logic [REG_IDX_W-1:0] dst;
    } uop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic uop_t mkUop(input logic [UOP_OP_W-1:0] op,
                                   input logic [REG_IDX_W-1:0] srcA,
                                   input logic [REG_IDX_W-1:0] srcB,
                                   input logic [REG_IDX_W-1:0] dst);
        uop_t u;
        u.op   = op;
        u.srcA = srcA;
        u.srcB = srcB;
        u.dst  = dst;
        return u;
    endfunction

endpackage

// File: rtl/strassen_ucode_rom.sv
// Combinational micro-code table: 17 ops build M1..M7 through the T0/T1
// scratch registers, then 8 ops fold the products into C11..C22.
module strassen_ucode_rom
    import strassen_pkg::*;
(
    input  logic [PC_W-1:0] i_pc,
    output uop_t            o_uop
);

    // Table lookup; entries past the schedule are a harmless scratch write.
    always_comb begin
        o_uop = mkUop(OP_ADD, REG_A11, REG_A11, REG_T0);
        case (i_pc)
            5'd0:  o_uop = mkUop(OP_ADD, REG_A11, REG_A22, REG_T0);
            5'd1:  o_uop = mkUop(OP_ADD, REG_B11, REG_B22, REG_T1);
            5'd2:  o_uop = mkUop(OP_MUL, REG_T0,  REG_T1,  REG_M1);
            5'd3:  o_uop = mkUop(OP_ADD, REG_A21, REG_A22, REG_T0);
            5'd4:  o_uop = mkUop(OP_MUL, REG_T0,  REG_B11, REG_M2);
            5'd5:  o_uop = mkUop(OP_SUB, REG_B12, REG_B22, REG_T0);
            5'd6:  o_uop = mkUop(OP_MUL, REG_A11, REG_T0,  REG_M3);
            5'd7:  o_uop = mkUop(OP_SUB, REG_B21, REG_B11, REG_T0);
            5'd8:  o_uop = mkUop(OP_MUL, REG_A22, REG_T0,  REG_M4);
            5'd9:  o_uop = mkUop(OP_ADD, REG_A11, REG_A12, REG_T0);
            5'd10: o_uop = mkUop(OP_MUL, REG_T0,  REG_B22, REG_M5);
            5'd11: o_uop = mkUop(OP_SUB, REG_A21, REG_A11, REG_T0);
            5'd12: o_uop = mkUop(OP_ADD, REG_B11, REG_B12, REG_T1);
            5'd13: o_uop = mkUop(OP_MUL, REG_T0,  REG_T1,  REG_M6);
            5'd14: o_uop = mkUop(OP_SUB, REG_A12, REG_A22, REG_T0);
            5'd15: o_uop = mkUop(OP_ADD, REG_B21, REG_B22, REG_T1);
            5'd16: o_uop = mkUop(OP_MUL, REG_T0,  REG_T1,  REG_M7);
            5'd17: o_uop = mkUop(OP_ADD, REG_M1,  REG_M4,  REG_C11);
            5'd18: o_uop = mkUop(OP_SUB, REG_C11, REG_M5,  REG_C11);
            5'd19: o_uop = mkUop(OP_ADD, REG_C11, REG_M7,  REG_C11);
            5'd20: o_uop = mkUop(OP_ADD, REG_M3,  REG_M5,  REG_C12);
            5'd21: o_uop = mkUop(OP_ADD, REG_M2,  REG_M4,  REG_C21);
            5'd22: o_uop = mkUop(OP_SUB, REG_M1,  REG_M2,  REG_C22);
            5'd23: o_uop = mkUop(OP_ADD, REG_C22, REG_M3,  REG_C22);
            5'd24: o_uop = mkUop(OP_ADD, REG_C22, REG_M6,  REG_C22);
            default: o_uop = mkUop(OP_ADD, REG_A11, REG_A11, REG_T0);
        endcase
    end

endmodule

// File: rtl/strassen_2x2_sequencer.sv
// Sequences an external shared ALU through the 25-op Strassen 2x2
// schedule, keeping operands and partial results in a 21-entry regfile.
module strassen_2x2_sequencer
    import strassen_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [4*WIDTH-1:0] i_a_mat,
    input  logic [4*WIDTH-1:0] i_b_mat,
    output logic               o_ready,
    output logic               o_done,
    output logic [4*WIDTH-1:0] o_c_mat,
    output logic [WIDTH-1:0]   o_alu_a,
    output logic [WIDTH-1:0]   o_alu_b,
    output logic [OP_W-1:0]    o_alu_op,
    input  logic [WIDTH-1:0]   i_alu_result
);

    state_e             r_state;
    state_e             w_nextState;
    logic               w_accept;
    logic               w_run;
    logic [PC_W-1:0]    r_pc;
    logic [WIDTH-1:0]   r_regs [NUM_REGS];
    logic [4*WIDTH-1:0] r_cMat;
    logic [4*WIDTH-1:0] w_cNext;
    uop_t               w_uop;

    strassen_ucode_rom u_rom (
        .i_pc  (r_pc),
        .o_uop (w_uop)
    );

    assign w_run   = (r_state == ST_RUN);
    assign o_c_mat = r_cMat;

    // The last op writes C22 on the same edge that loads c_mat, so that
    // element is forwarded straight from the ALU result.
    assign w_cNext = {
        (w_uop.dst == REG_C22) ? i_alu_result : r_regs[REG_C22],
        (w_uop.dst == REG_C21) ? i_alu_result : r_regs[REG_C21],
        (w_uop.dst == REG_C12) ? i_alu_result : r_regs[REG_C12],
        (w_uop.dst == REG_C11) ? i_alu_result : r_regs[REG_C11]
    };

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic plus handshake outputs; DONE can restart directly.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        o_ready     = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_pc == LAST_PC) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                o_ready = 1'b1;
                o_done  = 1'b1;
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_nextState = ST_RUN;
                end else begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // ALU drive: current micro-op operands while running, quiet zeros otherwise.
    always_comb begin
        o_alu_op = '0;
        o_alu_a  = '0;
        o_alu_b  = '0;
        if (w_run) begin
            o_alu_op = OP_W'(w_uop.op);
            o_alu_a  = r_regs[w_uop.srcA];
            o_alu_b  = r_regs[w_uop.srcB];
        end
    end

    // Program counter: restarts on acceptance, steps once per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_pc <= '0;
        else if (w_accept)              r_pc <= '0;
        else if (w_run && r_pc != LAST_PC) r_pc <= r_pc + 5'd1;
    end

    // Register file: operands latched on acceptance, ALU results written back while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < 4; k++) begin
                r_regs[k]     <= i_a_mat[k*WIDTH +: WIDTH];
                r_regs[k + 4] <= i_b_mat[k*WIDTH +: WIDTH];
            end
        end else if (w_run) begin
            r_regs[w_uop.dst] <= i_alu_result;
        end
    end

    // Result register: loads only on the edge that enters DONE, then holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     r_cMat <= '0;
        else if (w_run && r_pc == LAST_PC) r_cMat <= w_cNext;
    end

endmodule

// File: tb/tb_strassen_2x2_sequencer.sv
// Self-checking bench for strassen_2x2_sequencer: a behavioural ALU closes
// the loop, directed vectors push expected C matrices into a queue, and a
// monitor pops and compares whenever the DUT pulses done.
module tb_strassen_2x2_sequencer;

    localparam int W = 32;
    localparam int N = 4 * W;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] aMat;
    logic [N-1:0] bMat;
    logic         ready;
    logic         done;
    logic [N-1:0] cMat;
    logic [W-1:0] aluA;
    logic [W-1:0] aluB;
    logic [2:0]   aluOp;
    logic [W-1:0] aluResult;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] expQ [$];

    strassen_2x2_sequencer #(.WIDTH(W), .OP_W(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start),
        .i_a_mat      (aMat),
        .i_b_mat      (bMat),
        .o_ready      (ready),
        .o_done       (done),
        .o_c_mat      (cMat),
        .o_alu_a      (aluA),
        .o_alu_b      (aluB),
        .o_alu_op     (aluOp),
        .i_alu_result (aluResult)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the shared ALU; results wrap to W bits.
    always_comb begin
        aluResult = '0;
        case (aluOp)
            3'd0: aluResult = aluA + aluB;
            3'd1: aluResult = aluA - aluB;
            3'd2: aluResult = aluA * aluB;
            default: aluResult = '0;
        endcase
    end

    function automatic logic [N-1:0] pack4(input logic [W-1:0] e11, input logic [W-1:0] e12,
                                           input logic [W-1:0] e21, input logic [W-1:0] e22);
        return {e22, e21, e12, e11};
    endfunction

    task automatic checkOutput(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDone: got done=1 with empty queue, want no done");
            end else begin
                checkOutput("cMat", cMat, expQ.pop_front());
            end
        end
    end

    // Presents operands with start high; returns just after edge 0.
    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        aMat  = a;
        bMat  = b;
        start = 1'b1;
        @(posedge clk);
    endtask

    // Walks cycles 1..25 of a run checking busy status and the first ops,
    // optionally disturbing the inputs, then checks done in cycle 26.
    task automatic runBody(input bit corrupt, input int injCycle,
                           input logic [N-1:0] injA, input logic [N-1:0] injB,
                           input bit holdStart);
        int busyBad;
        logic [2:0] ops [3];
        busyBad = 0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            start = holdStart || (cyc == injCycle);
            if (cyc == injCycle) begin
                aMat = injA;
                bMat = injB;
            end
            if (corrupt && cyc == 2) begin
                aMat = '1;
                bMat = '1;
            end
            if (ready || done) busyBad++;
            if (cyc <= 3) ops[cyc-1] = aluOp;
        end
        checkOutput("busyWindow", N'(busyBad), N'(0));
        checkOutput("opTrace", N'({ops[0], ops[1], ops[2]}), N'({3'd0, 3'd0, 3'd2}));
        @(negedge clk);
        start = holdStart;
        checkOutput("doneCycle26", N'(done), N'(1));
        checkOutput("readyInDone", N'(ready), N'(1));
    endtask

    initial begin
        logic [N-1:0] a1, b1, c1, eye;
        a1  = pack4(32'd1, 32'd2, 32'd3, 32'd4);
        b1  = pack4(32'd5, 32'd6, 32'd7, 32'd8);
        c1  = pack4(32'd19, 32'd22, 32'd43, 32'd50);
        eye = pack4(32'd1, 32'd0, 32'd0, 32'd1);

        rst_n = 1'b0;
        start = 1'b0;
        aMat  = '0;
        bMat  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstReady", N'(ready), N'(1));
        checkOutput("rstDone", N'(done), N'(0));
        checkOutput("rstCMat", cMat, '0);
        checkOutput("rstAluOp", N'(aluOp), N'(0));
        checkOutput("rstAluAB", N'({aluA, aluB}), N'(0));
        rst_n = 1'b1;

        // Test 1: basic product, inputs disturbed after acceptance
        $display("[TB] test 1: basic product");
        expQ.push_back(c1);
        applyStimulus(a1, b1);
        runBody(1'b1, -1, '0, '0, 1'b0);
        @(negedge clk);
        checkOutput("donePulseEnds", N'(done), N'(0));
        checkOutput("cMatHolds", cMat, c1);
        checkOutput("idleAluOp", N'(aluOp), N'(0));

        // Test 2: negative values
        $display("[TB] test 2: signed operands");
        expQ.push_back(pack4(-32'sd2, 32'sd3, -32'sd4, -32'sd5));
        applyStimulus(pack4(-32'sd1, 32'd0, 32'd0, -32'sd1), pack4(32'sd2, -32'sd3, 32'sd4, 32'sd5));
        runBody(1'b0, -1, '0, '0, 1'b0);

        // Test 3: products wrap at 2^32
        $display("[TB] test 3: wraparound");
        expQ.push_back('0);
        applyStimulus(pack4(32'h0001_0000, 32'd0, 32'd0, 32'd0), pack4(32'h0001_0000, 32'd0, 32'd0, 32'd0));
        runBody(1'b0, -1, '0, '0, 1'b0);

        // Test 4: start during RUN is ignored
        $display("[TB] test 4: start ignored while running");
        expQ.push_back(c1);
        applyStimulus(a1, b1);
        runBody(1'b0, 10, eye, eye, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("noRestart", N'(ready), N'(1));

        // Test 5: reset in cycle 13 of a run, then a clean run
        $display("[TB] test 5: reset mid-run");
        applyStimulus(a1, b1);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstReady", N'(ready), N'(1));
        checkOutput("midRstDone", N'(done), N'(0));
        checkOutput("midRstCMat", cMat, '0);
        checkOutput("midRstAluOp", N'(aluOp), N'(0));
        @(negedge clk);
        rst_n = 1'b1;
        expQ.push_back(c1);
        applyStimulus(a1, b1);
        runBody(1'b0, -1, '0, '0, 1'b0);

        // Test 6: start held through DONE gives a back-to-back run
        $display("[TB] test 6: back-to-back runs");
        expQ.push_back(c1);
        expQ.push_back(c1);
        applyStimulus(a1, b1);
        runBody(1'b0, -1, '0, '0, 1'b1);
        runBody(1'b0, -1, '0, '0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2bIdleReady", N'(ready), N'(1));
        checkOutput("b2bIdleDone", N'(done), N'(0));

        repeat (3) @(negedge clk);
        checkOutput("pendingExpect", N'(expQ.size()), N'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no completion, want finish before 100000");
        $fatal(1, "[TB] timeout");
    end

endmodule
